// File: rtl/challenge_frame_packer.sv
// challenge_frame_packer
// Packs a byte stream describing one catalyst-screening challenge into the
// engine's wide challenge word, right-justified (first byte most significant),
// strobes the engine once, then waits for a breakthrough or a timeout and
// returns a one-cycle result record to the host.
//
// Ports:
//   clk, reset              rising-edge clock; synchronous active-low reset
//   in_byte/in_valid/in_last/in_ready   byte-stream handshake from the host
//   global_challenges       packed challenge word (MAX_BYTES*8 bits)
//   challenge_valid         one-cycle start strobe to the engine
//   breakthrough_detected, impact_potential, best_material_found  engine reply
//   busy                    high whenever not idle
//   result_valid, result_material, result_impact, timeout_flag  result record
//   overflow_err            sticky: current/last frame exceeded MAX_BYTES
//   challenge_count         completed challenges, saturating
module challenge_frame_packer #(
    parameter int MAX_BYTES      = 128,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [MAX_BYTES*8-1:0] global_challenges,
    output logic                   challenge_valid,
    input  logic                   breakthrough_detected,
    input  logic [31:0]            impact_potential,
    input  logic [2:0]             best_material_found,
    output logic                   busy,
    output logic                   result_valid,
    output logic [2:0]             result_material,
    output logic [31:0]            result_impact,
    output logic                   timeout_flag,
    output logic                   overflow_err,
    output logic [15:0]            challenge_count
);

    localparam int DW = MAX_BYTES * 8;
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] COUNT_FULL = CW'(MAX_BYTES);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1'b1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    state_t          state_r;
    state_t          next_s;
    logic [DW-1:0]   data_r;
    logic [CW-1:0]   count_r;
    logic [TW-1:0]   timer_r;
    logic [2:0]      material_r;
    logic [31:0]     impact_r;
    logic            timeout_r;
    logic            overflow_r;
    logic [15:0]     chal_count_r;
    logic            ready_s;
    logic            accept_s;
    logic            timer_done_s;

    // Handshake and strobes are pure decodes of the state register, so no
    // input ever reaches an output combinationally.
    assign ready_s      = (state_r == ST_IDLE) || (state_r == ST_LOAD);
    assign accept_s     = in_valid & ready_s;
    assign timer_done_s = (timer_r == TIMER_LAST);

    assign in_ready          = ready_s;
    assign busy              = (state_r != ST_IDLE);
    assign challenge_valid   = (state_r == ST_ISSUE);
    assign result_valid      = (state_r == ST_REPORT);
    assign global_challenges = data_r;
    assign result_material   = material_r;
    assign result_impact     = impact_r;
    assign timeout_flag      = timeout_r;
    assign overflow_err      = overflow_r;
    assign challenge_count   = chal_count_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode; a breakthrough takes priority over the timeout.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (accept_s) begin
                    if (in_last) begin
                        next_s = ST_ISSUE;
                    end else begin
                        next_s = ST_LOAD;
                    end
                end else begin
                    next_s = state_r;
                end
            end
            ST_ISSUE: next_s = ST_WAIT;
            ST_WAIT: begin
                if (breakthrough_detected || timer_done_s) begin
                    next_s = ST_REPORT;
                end else begin
                    next_s = ST_WAIT;
                end
            end
            ST_REPORT: next_s = ST_IDLE;
            default:   next_s = ST_IDLE;
        endcase
    end

    // Datapath: packing, overflow tracking, wait timer and result capture.
    // The result record and the completed-challenge count are updated on
    // the edge entering REPORT so they are coherent while result_valid is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_r       <= {DW{1'b0}};
            count_r      <= {CW{1'b0}};
            timer_r      <= {TW{1'b0}};
            material_r   <= 3'd0;
            impact_r     <= 32'd0;
            timeout_r    <= 1'b0;
            overflow_r   <= 1'b0;
            chal_count_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        data_r     <= {{(DW-8){1'b0}}, in_byte};
                        count_r    <= COUNT_ONE;
                        overflow_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        if (count_r < COUNT_FULL) begin
                            data_r  <= {data_r[DW-9:0], in_byte};
                            count_r <= count_r + COUNT_ONE;
                        end else begin
                            // Frame is full: byte is consumed but dropped.
                            overflow_r <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    timer_r <= {TW{1'b0}};
                end
                ST_WAIT: begin
                    timer_r <= timer_r + TIMER_ONE;
                    if (breakthrough_detected || timer_done_s) begin
                        if (breakthrough_detected) begin
                            material_r <= best_material_found;
                            impact_r   <= impact_potential;
                            timeout_r  <= 1'b0;
                        end else begin
                            material_r <= 3'd0;
                            impact_r   <= 32'd0;
                            timeout_r  <= 1'b1;
                        end
                        if (chal_count_r != 16'hFFFF) begin
                            chal_count_r <= chal_count_r + 16'd1;
                        end
                    end
                end
                ST_REPORT: begin
                    timer_r <= {TW{1'b0}};
                end
                default: begin
                    timer_r <= {TW{1'b0}};
                end
            endcase
        end
    end

endmodule
